dmem_resp: RTL

Data-memory responder for the EX/MEM/WB path. It accepts the single-cycle memory request issued by EX and performs stores in the request cycle. For loads it returns aligned, sign- or zero-extended data exactly one cycle after acceptance, which is the cycle in which write-back consumes `mem_rdata_i` after its one-cycle load stall. It owns a synchronous-read, byte-write data RAM and flags misaligned or out-of-range accesses.

---
 rtl/dmem_resp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data-memory responder: byte-write RAM, stores in the request cycle,
// registered loads with sign/zero extension one cycle later, and a registered fault flag.
module dmem_resp #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_mem_ena,
   input  logic        mem_rw_i,
   input  logic [2:0]  mem_funct3_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_fault_o
);
   localparam int   AW        = $clog2(DEPTH_WORDS);
   localparam logic ENABLE    = 1'b1;
   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   logic          accept;
   logic          misalign;
   logic          in_range;
   logic          fault_d;
   logic          ld_pending_d;
   logic          store_en;
   logic [31:0]   word_idx;
   logic [AW-1:0] ram_addr;
   logic [3:0]    byte_en;
   logic [31:0]   wdata_lanes;

   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   ram_q;
   logic          ld_pending_q;
   logic          fault_q;
   logic [2:0]    ld_funct3_q;
   logic [1:0]    ld_off_q;

   logic [7:0]    lane_b;
   logic [15:0]   lane_h;

   assign accept = ex_valid && (ex_mem_ena == ENABLE);

   // Subtraction wraps, so addresses below BASE_ADDR land far above the RAM and fault.
   assign word_idx = (mem_addr_i - BASE_ADDR) >> 2;
   assign in_range = (word_idx[31:AW] == '0);
   assign ram_addr = word_idx[AW-1:0];

   always_comb begin
      misalign    = 1'b0;
      byte_en     = 4'b0000;
      wdata_lanes = mem_wdata_i;
      case (mem_funct3_i)
         3'b000, 3'b100: begin
            byte_en     = 4'b0001 << mem_addr_i[1:0];
            wdata_lanes = {4{mem_wdata_i[7:0]}};
         end
         3'b001, 3'b101: begin
            misalign    = mem_addr_i[0];
            byte_en     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{mem_wdata_i[15:0]}};
         end
         3'b010: begin
            misalign = (mem_addr_i[1:0] != 2'b00);
            byte_en  = 4'b1111;
         end
         default: misalign = 1'b1;
      endcase
   end

   assign fault_d      = accept && (misalign || !in_range);
   assign store_en     = accept && (mem_rw_i == MEM_WRITE) && !fault_d;
   assign ld_pending_d = accept && (mem_rw_i == MEM_READ);

   always_ff @(posedge clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) ram[ram_addr][8*b +: 8] <= wdata_lanes[8*b +: 8];
         end
      end
   end

   // A held load re-executes the same read and captures the same fields, so it is idempotent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_pending_q <= 1'b0;
         fault_q      <= 1'b0;
         ld_funct3_q  <= 3'b000;
         ld_off_q     <= 2'b00;
         ram_q        <= 32'h0;
      end else begin
         ld_pending_q <= ld_pending_d;
         fault_q      <= fault_d;
         if (ld_pending_d) begin
            ld_funct3_q <= mem_funct3_i;
            ld_off_q    <= mem_addr_i[1:0];
            if (!fault_d) ram_q <= ram[ram_addr];
         end
      end
   end

   assign lane_b = ram_q[{ld_off_q, 3'b000} +: 8];
   assign lane_h = ld_off_q[1] ? ram_q[31:16] : ram_q[15:0];

   always_comb begin
      mem_rdata_o = 32'h0;
      if (ld_pending_q && !fault_q) begin
         case (ld_funct3_q)
            3'b000:  mem_rdata_o = {{24{lane_b[7]}}, lane_b};
            3'b100:  mem_rdata_o = {24'h0, lane_b};
            3'b001:  mem_rdata_o = {{16{lane_h[15]}}, lane_h};
            3'b101:  mem_rdata_o = {16'h0, lane_h};
            3'b010:  mem_rdata_o = ram_q;
            default: mem_rdata_o = 32'h0;
         endcase
      end
   end

   assign mem_fault_o = fault_q;
endmodule
